// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
// Purpose: scoreboard-entry struct, forward-code constants, stall counter width
//          and the operand-match helper shared by the controller and its bench.
// Ports:   none (package).
package hazard_ctrl_pkg;

    localparam int STALL_CNT_W = 16;

    // Destination field is sized for the widest supported register file;
    // narrower register addresses are zero-extended into it.
    localparam int SB_RD_W = 8;

    // EX operand select codes: 0 = pipeline register, k = result from stage k+1.
    localparam int FWD_NONE = 0;
    localparam int FWD_MEM  = 1;
    localparam int FWD_WB   = 2;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               regWrite;
        logic               memRead;
    } sbEntry_t;

    // True when a used source register is produced by this scoreboard entry.
    function automatic logic sbMatch(input logic used, input sbEntry_t e,
                                     input logic [SB_RD_W-1:0] rs, input logic r0Zero);
        return used && e.valid && e.regWrite && (e.rd == rs) && !(r0Zero && (rs == '0));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode-stage hazard bus between pipeline and controller
// Purpose: bundles the decode operands/class, branch and memory-freeze inputs and
//          the stall/bubble/flush/forward outputs of the hazard controller.
// Ports:   master drives decode-stage fields, branch_taken, mem_busy and reads the
//          controls; slave (the controller) is the mirror image.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int RA_W  = 3,
    parameter int DEPTH = 3
);
    localparam int FW = $clog2(DEPTH);

    logic                   id_valid;
    logic [RA_W-1:0]        id_rs1;
    logic [RA_W-1:0]        id_rs2;
    logic                   id_rs1_used;
    logic                   id_rs2_used;
    logic [RA_W-1:0]        id_rd;
    logic                   id_reg_write;
    logic                   id_mem_read;
    logic                   id_is_branch;
    logic                   branch_taken;
    logic                   mem_busy;

    logic                   stall_if;
    logic                   bubble_ex;
    logic                   flush_ifid;
    logic [FW-1:0]          fwd1_ex;
    logic [FW-1:0]          fwd2_ex;
    logic                   idfwd1;
    logic                   idfwd2;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_mem_read, id_is_branch,
               branch_taken, mem_busy,
        input  stall_if, bubble_ex, flush_ifid, fwd1_ex, fwd2_ex,
               idfwd1, idfwd2, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_mem_read, id_is_branch,
               branch_taken, mem_busy,
        output stall_if, bubble_ex, flush_ifid, fwd1_ex, fwd2_ex,
               idfwd1, idfwd2, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_sb_entry.sv
// rtl/hazard_ctrl_sb_entry.sv - one scoreboard stage register
// Purpose: holds one in-flight instruction's destination info; loads d each
//          cycle unless frozen, or loads an empty entry when clear is set.
// Ports:   clk, reset (async, active-high); freeze holds the entry; clear loads
//          an invalid entry; d next entry; q current entry.
module hz_sb_entry
    import hazard_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     freeze,
    input  logic     clear,
    input  sbEntry_t d,
    output sbEntry_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (!freeze) begin
            q <= clear ? sbEntry_t'('0) : d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard detection, stall/flush and forward select
// Purpose: tracks the destinations of the DEPTH instructions after decode and
//          derives load-use/branch stalls, IF/ID flush, EX forward codes and
//          decode-stage forwarding from the oldest stage, plus a stall counter.
// Ports:   clk; reset (async, active-high); bus (hazard_ctrl_if.slave) carrying
//          the decode operands/class, branch_taken, mem_busy and all controls.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RA_W    = 3,
    parameter int DEPTH   = 3,
    parameter bit R0_ZERO = 1'b1
)(
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    localparam int FW = $clog2(DEPTH);

    sbEntry_t sbQ [DEPTH];
    sbEntry_t headEntry;

    logic [SB_RD_W-1:0] rs1Ext;
    logic [SB_RD_W-1:0] rs2Ext;
    logic [DEPTH-1:0]   m1;
    logic [DEPTH-1:0]   m2;
    logic               loadUse;
    logic               branchHz;
    logic               hz;
    logic               issue;
    logic               clearHead;

    logic [FW-1:0]          fwd1Q;
    logic [FW-1:0]          fwd2Q;
    logic [STALL_CNT_W-1:0] stallCnt;

    assign rs1Ext = {{(SB_RD_W-RA_W){1'b0}}, bus.id_rs1};
    assign rs2Ext = {{(SB_RD_W-RA_W){1'b0}}, bus.id_rs2};

    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m1[i] = sbMatch(bus.id_rs1_used, sbQ[i], rs1Ext, R0_ZERO);
            m2[i] = sbMatch(bus.id_rs2_used, sbQ[i], rs2Ext, R0_ZERO);
        end
    end

    // A branch resolves in decode, so it must wait for any EX producer and for
    // a load one stage further on; ordinary ALU consumers only wait on a load in EX.
    assign loadUse  = bus.id_valid && (m1[0] || m2[0]) && sbQ[0].memRead;
    assign branchHz = bus.id_is_branch &&
                      ((m1[0] || m2[0]) || ((m1[1] || m2[1]) && sbQ[1].memRead));
    assign hz       = loadUse || branchHz;

    assign bus.stall_if   = hz || bus.mem_busy;
    assign bus.bubble_ex  = hz && !bus.mem_busy;
    assign bus.flush_ifid = bus.branch_taken && bus.id_valid && !hz && !bus.mem_busy;

    // Oldest stage supplies its write data straight to decode, but only when no
    // younger stage overrides the same register.
    assign bus.idfwd1 = m1[DEPTH-1] && !(|m1[DEPTH-2:0]);
    assign bus.idfwd2 = m2[DEPTH-1] && !(|m2[DEPTH-2:0]);

    // Instruction actually moving into EX this cycle (mem_busy is handled by freeze).
    assign issue     = bus.id_valid && !hz;
    assign clearHead = !issue;

    always_comb begin
        headEntry          = '0;
        headEntry.valid    = 1'b1;
        headEntry.rd       = {{(SB_RD_W-RA_W){1'b0}}, bus.id_rd};
        headEntry.regWrite = bus.id_reg_write;
        headEntry.memRead  = bus.id_mem_read;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : gSb
        if (i == 0) begin : gHead
            hz_sb_entry uEntry (
                .clk    (clk),
                .reset  (reset),
                .freeze (bus.mem_busy),
                .clear  (clearHead),
                .d      (headEntry),
                .q      (sbQ[0])
            );
        end else begin : gTail
            hz_sb_entry uEntry (
                .clk    (clk),
                .reset  (reset),
                .freeze (bus.mem_busy),
                .clear  (1'b0),
                .d      (sbQ[i-1]),
                .q      (sbQ[i])
            );
        end
    end

    // Youngest producer wins: scan from oldest forwardable stage down to EX so
    // the lowest matching index overwrites any older one.
    function automatic logic [FW-1:0] fwdCode(input logic [DEPTH-1:0] m);
        logic [FW-1:0] code;
        code = FW'(FWD_NONE);
        for (int i = DEPTH - 2; i >= 0; i--) begin
            if (m[i]) begin
                code = FW'(FWD_MEM + i);
            end
        end
        return code;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd1Q    <= FW'(FWD_NONE);
            fwd2Q    <= FW'(FWD_NONE);
            stallCnt <= '0;
        end else begin
            if (!bus.mem_busy) begin
                fwd1Q <= issue ? fwdCode(m1) : FW'(FWD_NONE);
                fwd2Q <= issue ? fwdCode(m2) : FW'(FWD_NONE);
            end
            if (bus.stall_if && (stallCnt != {STALL_CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end

    assign bus.fwd1_ex   = fwd1Q;
    assign bus.fwd2_ex   = fwd2Q;
    assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int RA_W    = 3;
    localparam int DEPTH   = 3;
    localparam bit R0_ZERO = 1'b1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.RA_W(RA_W), .DEPTH(DEPTH)) hif ();

    hazard_ctrl #(.RA_W(RA_W), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: list of in-flight instructions, index 0 = EX.
    bit mValid [DEPTH];
    int mRd    [DEPTH];
    bit mRw    [DEPTH];
    bit mMr    [DEPTH];
    int mFwd1, mFwd2, mCnt;

    function automatic void modelClear();
        for (int i = 0; i < DEPTH; i++) begin
            mValid[i] = 0; mRd[i] = 0; mRw[i] = 0; mMr[i] = 0;
        end
        mFwd1 = 0; mFwd2 = 0; mCnt = 0;
    endfunction

    // Position of the most recent in-flight writer of rs, or -1.
    function automatic int producer(input bit used, input int rs);
        if (!used || (R0_ZERO && rs == 0)) return -1;
        for (int i = 0; i < DEPTH; i++)
            if (mValid[i] && mRw[i] && mRd[i] == rs) return i;
        return -1;
    endfunction

    function automatic bit modelHz();
        int p1, p2;
        bit lu, br;
        p1 = producer(hif.id_rs1_used, int'(hif.id_rs1));
        p2 = producer(hif.id_rs2_used, int'(hif.id_rs2));
        lu = hif.id_valid && (p1 == 0 || p2 == 0) && mMr[0];
        br = hif.id_is_branch && (p1 == 0 || p2 == 0 || ((p1 == 1 || p2 == 1) && mMr[1]));
        return lu || br;
    endfunction

    function automatic logic [31:0] pack(input bit s, input bit b, input bit f, input bit i1,
                                         input bit i2, input int f1, input int f2, input int cnt);
        return {3'b0, s, b, f, i1, i2, 4'(f1), 4'(f2), 16'(cnt)};
    endfunction

    function automatic logic [31:0] modelPack();
        bit hz, mb;
        hz = modelHz();
        mb = hif.mem_busy;
        return pack(hz || mb, hz && !mb, hif.branch_taken && hif.id_valid && !hz && !mb,
                    producer(hif.id_rs1_used, int'(hif.id_rs1)) == DEPTH - 1,
                    producer(hif.id_rs2_used, int'(hif.id_rs2)) == DEPTH - 1,
                    mFwd1, mFwd2, mCnt);
    endfunction

    function automatic logic [31:0] dutPack();
        return pack(hif.stall_if, hif.bubble_ex, hif.flush_ifid, hif.idfwd1, hif.idfwd2,
                    int'(hif.fwd1_ex), int'(hif.fwd2_ex), int'(hif.stall_cnt));
    endfunction

    function automatic void modelAdvance();
        bit hz, issue;
        int p1, p2;
        hz = modelHz();
        p1 = producer(hif.id_rs1_used, int'(hif.id_rs1));
        p2 = producer(hif.id_rs2_used, int'(hif.id_rs2));
        if (!hif.mem_busy) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mValid[i] = mValid[i-1]; mRd[i] = mRd[i-1];
                mRw[i] = mRw[i-1]; mMr[i] = mMr[i-1];
            end
            issue = hif.id_valid && !hz;
            mValid[0] = issue;
            mRd[0] = int'(hif.id_rd); mRw[0] = hif.id_reg_write; mMr[0] = hif.id_mem_read;
            mFwd1 = (issue && p1 >= 0 && p1 <= DEPTH - 2) ? p1 + 1 : 0;
            mFwd2 = (issue && p2 >= 0 && p2 <= DEPTH - 2) ? p2 + 1 : 0;
        end
        if (hz || hif.mem_busy) mCnt = (mCnt < 65535) ? mCnt + 1 : 65535;
    endfunction

    task automatic setIn(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit rw, input bit mr, input bit br, input bit bt,
                         input bit mb);
        hif.id_valid = v; hif.id_rs1 = RA_W'(rs1); hif.id_rs2 = RA_W'(rs2);
        hif.id_rs1_used = u1; hif.id_rs2_used = u2; hif.id_rd = RA_W'(rd);
        hif.id_reg_write = rw; hif.id_mem_read = mr; hif.id_is_branch = br;
        hif.branch_taken = bt; hif.mem_busy = mb;
    endtask

    task automatic startCycle(input string name);
        @(negedge clk);
        check(name, dutPack(), modelPack());
    endtask

    task automatic endCycle();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        modelClear();
        check("reset_state", dutPack(), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit mr; bit br; bit bt;
        bit eS; bit eB; bit eF; bit eI1; bit eI2; int eF1; int eF2;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit mr,
                                bit br, bit bt, bit eS, bit eB, bit eF, bit eI1, bit eI2,
                                int eF1, int eF2);
        vec_t x;
        x.v = v; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2; x.rd = rd; x.rw = rw;
        x.mr = mr; x.br = br; x.bt = bt; x.eS = eS; x.eB = eB; x.eF = eF;
        x.eI1 = eI1; x.eI2 = eI2; x.eF1 = eF1; x.eF2 = eF2;
        return x;
    endfunction

    function automatic vec_t nop(int eF1, int eF2);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eF1, eF2);
    endfunction

    initial begin
        reset = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelClear();

        //        v rs1 rs2 u1 u2 rd rw mr br bt | S B F I1 I2 F1 F2
        // LW r2 ; ADD r3,r2,r1 (load-use)
        vt.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2, 1, 1, 1, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2, 1, 1, 1, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(nop(FWD_WB, FWD_NONE));
        vt.push_back(nop(0, 0));
        vt.push_back(nop(0, 0));
        // ADD r2 ; SUB r4,r2,r2
        vt.push_back(mk(1, 1, 1, 1, 1, 2, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2, 2, 1, 1, 4, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(nop(FWD_MEM, FWD_MEM));
        vt.push_back(nop(0, 0));
        vt.push_back(nop(0, 0));
        // ADD r5 ; NOP ; NOP ; BEQ r5,r0 taken
        vt.push_back(mk(1, 1, 1, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(nop(0, 0));
        vt.push_back(nop(0, 0));
        vt.push_back(mk(1, 5, 0, 1, 1, 0, 0, 0, 1, 1,  0, 0, 1, 1, 0, 0, 0));
        vt.push_back(nop(0, 0));
        vt.push_back(nop(0, 0));
        // ADD r6 ; BEQ r6,r1 taken
        vt.push_back(mk(1, 1, 1, 1, 1, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 6, 1, 1, 1, 0, 0, 0, 1, 1,  1, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 6, 1, 1, 1, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0, 0, 0));
        vt.push_back(nop(FWD_WB, FWD_NONE));
        vt.push_back(nop(0, 0));
        // LW r3 ; NOP ; BEQ r3,r3 (load one stage past EX)
        vt.push_back(mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(nop(0, 0));
        vt.push_back(mk(1, 3, 3, 1, 1, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 3, 3, 1, 1, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 0, 0));
        vt.push_back(nop(0, 0));
        vt.push_back(nop(0, 0));
        // LW r0 ; ADD r1,r0,r0 (r0 never hazards)
        vt.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(nop(0, 0));
        // branch_taken with no valid instruction
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));

        doReset();

        foreach (vt[k]) begin
            setIn(vt[k].v, vt[k].rs1, vt[k].rs2, vt[k].u1, vt[k].u2, vt[k].rd, vt[k].rw,
                  vt[k].mr, vt[k].br, vt[k].bt, 0);
            startCycle($sformatf("vec%0d_model", k));
            check($sformatf("vec%0d", k), dutPack() & 32'hFFFF_0000,
                  pack(vt[k].eS, vt[k].eB, vt[k].eF, vt[k].eI1, vt[k].eI2,
                       vt[k].eF1, vt[k].eF2, 0));
            endCycle();
        end
        check("table_stall_cnt", 32'(hif.stall_cnt), 32'd3);

        // Load-use under a 3-cycle memory freeze.
        doReset();
        setIn(1, 7, 7, 1, 1, 1, 1, 0, 0, 0, 0);          // ADD r1,r7,r7
        startCycle("frz_add"); endCycle();
        setIn(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0);          // LW r2,0(r1)
        startCycle("frz_lw"); endCycle();
        for (int c = 0; c < 3; c++) begin
            setIn(1, 2, 1, 1, 1, 3, 1, 0, 0, 0, 1);      // ADD r3,r2,r1, mem busy
            startCycle($sformatf("frz_busy%0d", c));
            check($sformatf("frz_busy%0d_ctl", c),
                  {hif.stall_if, hif.bubble_ex, 2'(hif.fwd1_ex)}, {1'b1, 1'b0, 2'(FWD_MEM)});
            endCycle();
        end
        setIn(1, 2, 1, 1, 1, 3, 1, 0, 0, 0, 0);
        startCycle("frz_bubble");
        check("frz_bubble_ctl", {hif.stall_if, hif.bubble_ex}, 2'b11);
        endCycle();
        startCycle("frz_issue");
        check("frz_issue_ctl", {hif.stall_if, hif.idfwd2}, 2'b01);
        endCycle();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        startCycle("frz_ex");
        check("frz_ex_fwd", {2'(hif.fwd1_ex), 2'(hif.fwd2_ex)}, {2'(FWD_WB), 2'(FWD_NONE)});
        check("frz_stall_cnt", 32'(hif.stall_cnt), 32'd4);
        endCycle();

        // Reset asserted in the middle of a load-use stall.
        doReset();
        setIn(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0);
        startCycle("rst_lw"); endCycle();
        setIn(1, 2, 1, 1, 1, 3, 1, 0, 0, 0, 0);
        startCycle("rst_stall");
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", dutPack(), 32'h0);
        modelClear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        startCycle("rst_after");
        check("rst_after_nostall", 32'(hif.stall_if), 32'd0);
        endCycle();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            setIn($urandom_range(3, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(3, 0),
                  $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
                  $urandom_range(3, 0) == 0, $urandom_range(1, 0),
                  $urandom_range(7, 0) == 0);
            startCycle($sformatf("rand%0d", n));
            endCycle();
        end

        // Stall counter saturation.
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (65540) @(posedge clk);
        #1;
        mCnt = 65535;
        startCycle("sat0");
        check("sat_value", 32'(hif.stall_cnt), 32'h0000_FFFF);
        endCycle();
        startCycle("sat1");
        endCycle();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        startCycle("sat2");
        endCycle();
        check("sat_hold", 32'(hif.stall_cnt), 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter RA_W, 3: register-address width.
REQ-002 Parameter DEPTH, 3: tracked stages after decode (EX, MEM, WB, ...), range 2..8.
REQ-003 Parameter R0_ZERO, 1: when 1, register 0 never matches any hazard or forward.
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port reset  in  1: asynchronous, active-high.
REQ-006 Ports id_valid  in  1; id_rs1, id_rs2  in  RA_W; id_rs1_used, id_rs2_used  in  1: decode-stage operands.
REQ-007 Ports id_rd  in  RA_W; id_reg_write, id_mem_read, id_is_branch  in  1: decode-stage destination and class.
REQ-008 Ports branch_taken  in  1 (jump resolved in decode); mem_busy  in  1 (multi-cycle memory freeze).
REQ-009 Ports stall_if  out  1 (hold PC and IF/ID); bubble_ex  out  1 (load NOP into ID/EX); flush_ifid  out  1.
REQ-010 Ports fwd1_ex, fwd2_ex  out  $clog2(DEPTH): registered EX operand select; 0 = pipeline register, k = result from stage k+1 (1 = MEM, 2 = WB).
REQ-011 Ports idfwd1, idfwd2  out  1: combinational; decode operand taken from the oldest tracked stage (WB write data).
REQ-012 Port stall_cnt  out  16: saturating stall-cycle counter.

Function
REQ-013 Scoreboard: DEPTH entries {valid, rd, reg_write, mem_read}; entry 0 = EX, entry DEPTH-1 = oldest.
REQ-014 Operand match: source used, entry valid, entry reg_write, rd equal, and not (R0_ZERO and rd = 0).
REQ-015 Load-use hazard: id_valid and any used source matches entry 0 with mem_read.
REQ-016 Branch hazard: id_is_branch and a used source matches entry 0 (any writer), or entry 1 with mem_read.
REQ-017 hz = load-use or branch hazard; stall_if = hz or mem_busy; bubble_ex = hz and not mem_busy.
REQ-018 flush_ifid = branch_taken and id_valid and not hz and not mem_busy; branch_taken ignored otherwise (re-evaluated next cycle).
REQ-019 Shift when mem_busy = 0: entry[i] <= entry[i-1]; entry 0 <= ID instruction, or an invalid entry when bubble_ex or not id_valid.
REQ-020 When mem_busy = 1: scoreboard, fwd1_ex, fwd2_ex frozen.
REQ-021 fwdN_ex computed at ID over entries 0..DEPTH-2; the youngest (lowest index) match wins; code = index+1; registered on shift; 0 when bubble or no match.
REQ-022 idfwdN = match against entry DEPTH-1 and no younger match.
REQ-023 stall_cnt increments by 1 each cycle stall_if = 1; holds at 0xFFFF.
REQ-024 Latency: stall/flush/idfwd same cycle (combinational); fwdN_ex valid one cycle after issue, aligned with instruction in EX.

Reset
REQ-025 Reset asserted: all entries invalid; fwd1_ex, fwd2_ex = 0; stall_cnt = 0; therefore stall_if, bubble_ex, flush_ifid, idfwdN = 0.
REQ-026 Reset mid-stall or mid-freeze clears immediately; first post-reset cycle sees an empty scoreboard.

Structure
REQ-027 Shared package holds the scoreboard-entry struct, forward-code constants (FWD_NONE, FWD_MEM, FWD_WB), and STALL_CNT_W = 16.
REQ-028 One sub-module, hz_sb_entry, holds a single scoreboard stage register with freeze and clear; hazard_ctrl instantiates DEPTH copies.

Verification
REQ-029 LW r2 then ADD r3,r2,r1 -> one cycle stall_if=1, bubble_ex=1; ADD issues next cycle with fwd1_ex=2; stall_cnt=1.
REQ-030 ADD r2 then SUB r4,r2,r2 -> no stall; fwd1_ex=1, fwd2_ex=1 the cycle SUB is in EX.
REQ-031 ADD r5; NOP; NOP; BEQ r5,r0 -> no stall, idfwd1=1, idfwd2=0 (R0_ZERO), branch_taken=1 gives flush_ifid=1.
REQ-032 ADD r6 immediately followed by BEQ r6,r1 with branch_taken=1 -> stall 1 cycle, flush_ifid=0 during stall, flush_ifid=1 the next cycle.
REQ-033 mem_busy held 3 cycles during load-use -> stall_if=1, scoreboard/fwd frozen, stall_cnt += 3; then normal bubble.
REQ-034 Reset pulse mid load-use stall -> outputs 0 asynchronously; stall_cnt forced to 0xFFFF by 65535+ stalls stays 0xFFFF.
